alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Sequencing front-end for the sail-core `alu`: accepts one ALU operation from decode over a valid/ready handshake and drives `ALUctl`/`A`/`B` into the ALU. It holds the operands through the ALU's registered-output latency, then captures `ALUOut` and `Branch_Enable` and returns them downstream over a second valid/ready handshake with a destination tag. Operands must stay stable for the capture cycle, because the ALU's `Branch_Enable` is combinational on both the registered `ALUOut` and the live `A`/`B`.

## Interface
Parameters:
- `TAG_W`, default 5: width of the opaque tag carried with each op (rd index).

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  decode presents an op
- `in_ready`  out  1  block accepts the op this cycle
- `in_ctl`  in  7  ALUctl encoding (`[6:4]` branch, `[3:0]` op)
- `in_a`, `in_b`  in  32  operands
- `in_tag`  in  TAG_W  tag returned with the result
- `alu_ctl`  out  7  to ALU `ALUctl`
- `alu_a`, `alu_b`  out  32  to ALU `A`, `B`
- `alu_out`  in  32  from ALU `ALUOut`
- `alu_branch`  in  1  from ALU `Branch_Enable`
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream consumes the result
- `out_result`  out  32  captured `ALUOut`
- `out_branch`  out  1  captured `Branch_Enable`
- `out_tag`  out  TAG_W  tag of this result

## Operation
- FSM states: `IDLE`, `EXEC`, `CAPT`, `RESP`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid`: latch `in_ctl`/`in_a`/`in_b`/`in_tag` into the `alu_*` registers and the tag register, then go to `EXEC`.
- `EXEC`: `alu_*` held. The ALU registers its result at the end of this cycle. Go to `CAPT`.
- `CAPT`:
  - `alu_*` still held, so `alu_branch` is evaluated against the correct `A`/`B`.
  - Latch `alu_out` → `out_result` and `alu_branch` → `out_branch`.
  - Go to `RESP`.
- `RESP`:
  - `out_valid`=1. `out_*` are stable until the handshake completes.
  - On `out_ready`: go to `IDLE` (or `EXEC`, see Configuration).
- `alu_*` registers change only when an op is accepted. Between ops they hold the last op's values.
- `in_ready` is combinational from state (and from `out_ready` when overlap is enabled). There is no path from `in_valid` to `in_ready`.
- All `out_*` are registered.
- No arithmetic is performed in this block; the 32-bit data passes through unchanged.

## Timing
- Accept at cycle T → ALU driven T+1 → `alu_out` valid T+2 (captured at the end of T+2) → `out_valid`=1 from T+3.
- Latency from accept to `out_valid` is 3 cycles.
- Base throughput: one op per 4 cycles (accept, EXEC, CAPT, RESP handshake).
- Backpressure: while `out_ready`=0 in `RESP`:
  - `out_*` are frozen and `in_ready`=0.
  - No new op enters; `alu_*` stay unchanged.
- Reset values, applied at the first clock edge with `rst`=1:
  - state = `IDLE`
  - `out_valid`=0, `out_result`=0, `out_branch`=0, `out_tag`=0
  - `alu_ctl`=0, `alu_a`=0, `alu_b`=0
  - `in_ready`=1 once `rst` is deasserted
- `rst` during `EXEC`, `CAPT` or `RESP`: the op is discarded with no output handshake. `rst` overrides any simultaneous `in_valid` or `out_ready`.
- `in_valid` with `in_ready`=0: ignored. Decode must hold its op until it is accepted.

## Configuration
- `SAIL_ALU_ISSUE_OVERLAP_EN` defined:
  - In `RESP`, `in_ready` = `out_ready`.
  - A simultaneous output handshake and input accept moves `RESP`→`EXEC` directly, loading the new op into `alu_*`.
  - Throughput rises to one op per 3 cycles with `out_ready` held at 1.
  - `out_*` still change only at the `CAPT` of the next op.
- Not defined: `in_ready`=1 only in `IDLE`, and `RESP`+`out_ready` always returns to `IDLE`.

## Test plan
- ADD op, `in_a`=5, `in_b`=7, tag 3, `out_ready`=1 → `out_valid` 3 cycles after accept, `out_result`=12, `out_tag`=3, one-cycle pulse.
- SUB, A=3, B=5 → `out_result`=0xFFFFFFFE.
- BEQ+SUB, A=B=9 → `out_result`=0, `out_branch`=1. BLT, A=0xFFFFFFFF, B=1 → `out_branch`=1. BLTU with the same operands → `out_branch`=0.
- Hold `out_ready`=0 for 5 cycles in `RESP`, with `in_valid`=1 and a second op presented → `out_*` stable, `in_ready`=0. After `out_ready` rises the second op is accepted and its result is correct.
- Assert `rst` for 1 cycle during `CAPT` → next cycle `out_valid`=0 and all outputs at reset values. A fresh op afterwards completes normally.
- With `SAIL_ALU_ISSUE_OVERLAP_EN`: 4 back-to-back ops, `out_ready`=1 → results arrive every 3 cycles, in order, with correct tags. Without the macro, results arrive every 4 cycles.

Source files
------------

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - issue/capture sequencer wrapping the registered-output sail-core ALU
// Optional macro SAIL_ALU_ISSUE_OVERLAP_EN: accept the next op during the result handshake.
module alu_issue_seq #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_ctl,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [6:0]       alu_ctl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic             alu_branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_branch,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         alu_ctl_q;
    logic [31:0]        alu_a_q, alu_b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               out_valid_q;
    logic [31:0]        out_result_q;
    logic               out_branch_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               ready_c;
    logic               load_c;
    logic               capture_c;

    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                capture_c = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
`ifdef SAIL_ALU_ISSUE_OVERLAP_EN
                ready_c = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? EXEC : IDLE;
                end
`else
                if (out_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_c = in_valid && ready_c;

    // Operands stay held through CAPT: the ALU's branch flag reads live A/B.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_ctl_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_branch_q <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == RESP);
            if (load_c) begin
                alu_ctl_q <= in_ctl;
                alu_a_q   <= in_a;
                alu_b_q   <= in_b;
                tag_q     <= in_tag;
            end
            if (capture_c) begin
                out_result_q <= alu_out;
                out_branch_q <= alu_branch;
                out_tag_q    <= tag_q;
            end
        end
    end

    assign in_ready   = ready_c;
    assign alu_ctl    = alu_ctl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_branch = out_branch_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - scoreboard bench for alu_issue_seq with a behavioural sail-core ALU
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_ctl = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_tag = '0;
    logic [6:0]  alu_ctl;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_out_m = '0;
    logic        alu_branch_m;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_branch;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
`ifdef SAIL_ALU_ISSUE_OVERLAP_EN
    localparam int PERIOD = 3;
`else
    localparam int PERIOD = 4;
`endif

    alu_issue_seq #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out_m), .alu_branch(alu_branch_m),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_branch(out_branch), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in: registered ALUOut, branch flag combinational on ALUOut and live A/B
    always @(posedge clk) begin
        case (alu_ctl[3:0])
            4'b0010: alu_out_m <= alu_a + alu_b;
            4'b0110: alu_out_m <= alu_a - alu_b;
            default: alu_out_m <= 32'h0;
        endcase
    end
    always_comb begin
        alu_branch_m = 1'b0;
        case (alu_ctl[6:4])
            3'b001: alu_branch_m = (alu_out_m == 32'h0);
            3'b010: alu_branch_m = (alu_out_m != 32'h0);
            3'b011: alu_branch_m = ($signed(alu_a) < $signed(alu_b));
            3'b100: alu_branch_m = ($signed(alu_a) >= $signed(alu_b));
            3'b101: alu_branch_m = (alu_a < alu_b);
            3'b110: alu_branch_m = (alu_a >= alu_b);
            default: alu_branch_m = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output handshake is checked against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", out_result, e.res);
                check("branch", {31'd0, out_branch}, {31'd0, e.br});
                check("tag", {27'd0, out_tag}, {27'd0, e.tag});
            end
        end
    end

    task automatic issue(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input logic br,
                         input bit expect_out, output int acc_cyc);
        exp_t e;
        bit   ok;
        if (expect_out) begin
            e.res = res; e.br = br; e.tag = tag;
            sb.push_back(e);
        end
        in_valid = 1'b1; in_ctl = ctl; in_a = a; in_b = b; in_tag = tag;
        ok = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, vcyc, dummy;
        bit seen;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_branch", {31'd0, out_branch}, 32'd0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);
        check("rst_alu_ctl", {25'd0, alu_ctl}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // ADD: latency and single-cycle valid pulse
        issue(7'h02, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b1, acc);
        seen = 1'b0; vcyc = -1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; vcyc = cyc; end
        end
        check("add_latency", vcyc - acc, 32'd3);
        @(negedge clk);
        check("add_pulse", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        issue(7'h06, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE, 1'b0, 1'b1, dummy);
        issue(7'h16, 32'd9, 32'd9, 5'd5, 32'h0, 1'b1, 1'b1, dummy);
        issue(7'h36, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'hFFFF_FFFE, 1'b1, 1'b1, dummy);
        issue(7'h56, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, dummy);
        drain();

        // Backpressure for 5 cycles with a second op waiting
        out_ready = 1'b0;
        issue(7'h02, 32'h10, 32'h20, 5'd8, 32'h30, 1'b0, 1'b1, dummy);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("bp_valid_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        fork
            issue(7'h02, 32'd100, 32'd1, 5'd9, 32'd101, 1'b0, 1'b1, dummy);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_out_result", out_result, 32'h30);
                    check("bp_out_tag", {27'd0, out_tag}, 32'd8);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_alu_a", alu_a, 32'h10);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while in CAPT discards the op
        issue(7'h02, 32'd1, 32'd1, 5'd10, 32'd2, 1'b0, 1'b0, dummy);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstc_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstc_out_result", out_result, 32'd0);
        check("rstc_out_branch", {31'd0, out_branch}, 32'd0);
        check("rstc_out_tag", {27'd0, out_tag}, 32'd0);
        check("rstc_alu_a", alu_a, 32'd0);
        check("rstc_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("rstc_no_output", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        issue(7'h02, 32'd2, 32'd2, 5'd11, 32'd4, 1'b0, 1'b1, dummy);
        drain();

        // Back-to-back throughput
        hs_cyc.delete();
        issue(7'h02, 32'h1111_1111, 32'h2222_2222, 5'd12, 32'h3333_3333, 1'b0, 1'b1, dummy);
        issue(7'h06, 32'h100, 32'h1, 5'd13, 32'hFF, 1'b0, 1'b1, dummy);
        issue(7'h26, 32'd4, 32'd4, 5'd14, 32'h0, 1'b0, 1'b1, dummy);
        issue(7'h62, 32'h8000_0000, 32'h7FFF_FFFF, 5'd15, 32'hFFFF_FFFF, 1'b1, 1'b1, dummy);
        drain();
        check("tp_count", hs_cyc.size(), 32'd4);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check("tp_spacing", hs_cyc[i] - hs_cyc[i-1], PERIOD);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
